// File: rtl/bit_serial_pkg.sv
// rtl/bit_serial_pkg.sv - shared types and constants for the bit-serial adder tree sequencer
package bit_serial_pkg;

  localparam int FRAME_BITS = 32;

  typedef logic [4:0] bit_cnt_t;

  localparam bit_cnt_t LAST_BIT = bit_cnt_t'(FRAME_BITS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/bit_serial_deserializer.sv
// rtl/bit_serial_deserializer.sv - marker-aligned collector turning per-lane result bits into parallel words
module bit_serial_deserializer
  import bit_serial_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_marker,
  input  logic [LANES-1:0]            i_bits,
  output logic                        o_push,
  output logic [LANES*FRAME_BITS-1:0] o_data
);

  logic     r_active;
  bit_cnt_t r_col_cnt;

  // The marker says bit 0 of a frame arrives next cycle; count until the frame completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active  <= 1'b0;
      r_col_cnt <= '0;
    end else if (i_marker) begin
      r_active  <= 1'b1;
      r_col_cnt <= '0;
    end else if (r_active) begin
      if (r_col_cnt == LAST_BIT) begin
        r_active <= 1'b0;
      end
      r_col_cnt <= r_col_cnt + 1'b1;
    end
  end

  // A push is issued on the cycle the last bit is present, so the word is complete one edge earlier.
  assign o_push = r_active && (r_col_cnt == LAST_BIT);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [FRAME_BITS-1:0] r_word;
    logic [FRAME_BITS-1:0] w_word;

    // Capture this lane's result bit at its position within the frame.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_word <= '0;
      end else if (r_active) begin
        r_word[r_col_cnt] <= i_bits[g];
      end
    end

    // The top bit bypasses the register so the pushed word includes the bit arriving now.
    always_comb begin
      w_word                 = r_word;
      w_word[FRAME_BITS-1]   = i_bits[g];
    end

    assign o_data[g*FRAME_BITS +: FRAME_BITS] = w_word;
  end

endmodule

// File: rtl/adder_tree_frame_sequencer.sv
// rtl/adder_tree_frame_sequencer.sv - serializes operand vectors into tree frames and collects sums
module adder_tree_frame_sequencer
  import bit_serial_pkg::*;
#(
  parameter int N_IN      = 8,
  parameter int LANES     = 8,
  parameter int IN_W      = 8,
  parameter int TREE_LAT  = 3,
  parameter int OUT_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_IN*LANES*IN_W-1:0]  in_data,
  output logic                        tree_reset,
  output logic                        tree_enable,
  output logic [N_IN*LANES-1:0]       tree_in,
  input  logic [LANES-1:0]            tree_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*FRAME_BITS-1:0] out_data
);

  localparam int FRAME = FRAME_BITS;
  localparam int OPS   = N_IN * LANES;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  logic                    r_rst_q;
  logic                    r_tree_reset;
  seq_state_e              r_state;
  bit_cnt_t                r_bit_cnt;
  logic [OPS*IN_W-1:0]     r_frame;
  logic [CNT_W-1:0]        r_credit;
  logic [TREE_LAT-1:0]     r_marker;
  logic [LANES*FRAME-1:0]  r_mem [OUT_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;

  logic                    w_accept;
  logic                    w_pop;
  logic                    w_push;
  logic [LANES*FRAME-1:0]  w_push_data;
  logic [OPS*IN_W-1:0]     w_frame_shift;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Hold the tree in reset for one extra cycle after the sequencer leaves reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rst_q      <= 1'b1;
      r_tree_reset <= 1'b1;
    end else begin
      r_rst_q      <= 1'b0;
      r_tree_reset <= r_rst_q;
    end
  end

  assign tree_reset  = r_tree_reset;
  assign tree_enable = (r_state == SHIFT);
  assign in_ready    = (r_credit != '0) && !r_tree_reset &&
                       ((r_state == IDLE) || (r_bit_cnt == LAST_BIT));
  assign w_accept    = in_valid && in_ready;
  assign out_valid   = (r_count != '0);
  assign w_pop       = out_valid && out_ready;

  // Each operand shifts right arithmetically, so its LSB walks through the bits and then repeats the sign.
  for (genvar g = 0; g < OPS; g++) begin : g_op
    assign w_frame_shift[g*IN_W +: IN_W] = {r_frame[g*IN_W+IN_W-1], r_frame[g*IN_W+1 +: IN_W-1]};
    assign tree_in[g] = tree_enable & r_frame[g*IN_W];
  end

  // Serializer FSM: frames run to completion and a new one may start on the last bit of the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_frame   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state   <= SHIFT;
            r_bit_cnt <= '0;
            r_frame   <= in_data;
          end
        end
        SHIFT: begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            if (w_accept) begin
              r_frame <= in_data;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_frame <= w_frame_shift;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // One credit per output slot: a frame only starts if its result is sure to find room.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credit <= CNT_W'(OUT_DEPTH);
    end else if (w_accept && !w_pop) begin
      r_credit <= r_credit - 1'b1;
    end else if (!w_accept && w_pop) begin
      r_credit <= r_credit + 1'b1;
    end
  end

  // Delay the accept pulse by the tree latency to mark where result bit 0 will arrive.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_marker <= '0;
    end else begin
      r_marker[0] <= w_accept;
      for (int k = 1; k < TREE_LAT; k++) begin
        r_marker[k] <= r_marker[k-1];
      end
    end
  end

  bit_serial_deserializer #(
    .LANES (LANES)
  ) u_deser (
    .clk      (clk),
    .reset    (reset),
    .i_marker (r_marker[TREE_LAT-1]),
    .i_bits   (tree_result),
    .o_push   (w_push),
    .o_data   (w_push_data)
  );

  // Output FIFO storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // First-word-fall-through head; zero while empty.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = r_mem[r_rd_ptr];
    end
  end

endmodule

// File: tb/tb_adder_tree_frame_sequencer.sv
// tb/tb_adder_tree_frame_sequencer.sv - scoreboard bench with a behavioural bit-serial tree model
module tb_adder_tree_frame_sequencer;

  localparam int N_IN     = 8;
  localparam int LANES    = 8;
  localparam int IN_W     = 8;
  localparam int TREE_LAT = 3;
  localparam int FRAME    = 32;
  localparam int DW       = N_IN * LANES * IN_W;
  localparam int OW       = LANES * FRAME;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            tree_reset;
  logic            tree_enable;
  logic [N_IN*LANES-1:0] tree_in;
  logic [LANES-1:0] tree_result;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [OW-1:0]   out_data;

  always #5 clk = ~clk;

  adder_tree_frame_sequencer #(
    .N_IN(N_IN), .LANES(LANES), .IN_W(IN_W), .TREE_LAT(TREE_LAT), .OUT_DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .tree_reset(tree_reset), .tree_enable(tree_enable), .tree_in(tree_in),
    .tree_result(tree_result), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [OW-1:0] sb_q [$];
  int last_pop = -1;
  bit gap_chk  = 1'b0;
  bit en_watch = 1'b0;
  int en_gaps  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural adder tree: per-lane serial multi-operand adder, TREE_LAT cycles of latency.
  logic [LANES-1:0] m_pipe [TREE_LAT+1];
  int m_carry [LANES];
  int m_bit = 0;

  always @(negedge clk) begin
    logic [LANES-1:0] nb;
    int s;
    nb = '0;
    if (tree_reset) begin
      m_bit = 0;
      for (int l = 0; l < LANES; l++) m_carry[l] = 0;
    end else if (tree_enable) begin
      for (int l = 0; l < LANES; l++) begin
        s = (m_bit == 0) ? 0 : m_carry[l];
        for (int i = 0; i < N_IN; i++) s += int'(tree_in[i*LANES+l]);
        nb[l] = s[0];
        m_carry[l] = s >> 1;
      end
      m_bit = (m_bit + 1) % FRAME;
    end
    m_pipe[0] <= tree_reset ? '0 : nb;
    for (int k = 1; k <= TREE_LAT; k++) m_pipe[k] <= tree_reset ? '0 : m_pipe[k-1];
  end

  assign tree_result = m_pipe[TREE_LAT];

  // Scoreboard: compare every popped vector against the oldest expected one.
  always begin
    @(negedge clk);
    #2;
    if (en_watch && !tree_enable) en_gaps++;
    if (out_valid && out_ready) begin
      chk_eq("sb_has_entry", OW'(sb_q.size() != 0), OW'(1));
      if (sb_q.size() != 0) begin
        chk_eq("sum", out_data, sb_q.pop_front());
        if (gap_chk) begin
          if (last_pop >= 0) chk_eq("pop_gap", OW'(cyc - last_pop), OW'(FRAME));
          last_pop = cyc;
        end
      end
    end
  end

  function automatic logic [DW-1:0] vec_const(input int v);
    logic [DW-1:0] d;
    for (int k = 0; k < N_IN*LANES; k++) d[k*IN_W +: IN_W] = IN_W'(v);
    return d;
  endfunction

  function automatic logic [DW-1:0] vec_alt();
    logic [DW-1:0] d;
    for (int i = 0; i < N_IN; i++)
      for (int l = 0; l < LANES; l++)
        d[(i*LANES+l)*IN_W +: IN_W] = (i % 2 == 0) ? 8'h80 : 8'h7F;
    return d;
  endfunction

  // Inputs {a,b,a,b,b,b,b,a} on even lanes, a and b swapped on odd lanes.
  function automatic logic [DW-1:0] vec_ab(input int a, input int b);
    logic [DW-1:0] d;
    logic [7:0] sel;
    logic pick_a;
    sel = 8'b1000_0101;
    for (int i = 0; i < N_IN; i++)
      for (int l = 0; l < LANES; l++) begin
        pick_a = sel[i] ^ (l % 2 == 1);
        d[(i*LANES+l)*IN_W +: IN_W] = IN_W'(pick_a ? a : b);
      end
    return d;
  endfunction

  function automatic logic [OW-1:0] exp_ab(input int a, input int b);
    logic [OW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*FRAME +: FRAME] = (l % 2 == 0) ? 3*a + 5*b : 3*b + 5*a;
    return r;
  endfunction

  function automatic logic [OW-1:0] calc(input logic [DW-1:0] d);
    logic [OW-1:0] r;
    int s;
    for (int l = 0; l < LANES; l++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++) s += int'($signed(d[(i*LANES+l)*IN_W +: IN_W]));
      r[l*FRAME +: FRAME] = s;
    end
    return r;
  endfunction

  // Offer one vector (called just after a negedge); returns on the negedge after acceptance.
  task automatic send(input logic [DW-1:0] d, input logic [OW-1:0] e);
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 200 && !in_ready; n++) @(negedge clk);
    chk_eq("send_accepted", OW'(in_ready), OW'(1));
    if (in_ready) begin
      sb_q.push_back(e);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && (sb_q.size() != 0 || out_valid); n++) @(negedge clk);
    chk_eq("drained", OW'(sb_q.size() == 0 && !out_valid), OW'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    bit rnd_done;
    logic [DW-1:0] d;

    repeat (3) @(negedge clk);
    chk_eq("rst_in_ready", OW'(in_ready), OW'(0));
    chk_eq("rst_tree_enable", OW'(tree_enable), OW'(0));
    chk_eq("rst_tree_in", OW'(tree_in), OW'(0));
    chk_eq("rst_out_valid", OW'(out_valid), OW'(0));
    chk_eq("rst_out_data", out_data, OW'(0));
    chk_eq("rst_tree_reset", OW'(tree_reset), OW'(1));
    reset = 1'b0;
    @(negedge clk);
    chk_eq("tree_reset_stretch", OW'(tree_reset), OW'(1));
    chk_eq("in_ready_during_stretch", OW'(in_ready), OW'(0));
    @(negedge clk);
    chk_eq("tree_reset_released", OW'(tree_reset), OW'(0));
    chk_eq("in_ready_after_reset", OW'(in_ready), OW'(1));

    // All operands -10, check first-result latency.
    out_ready = 1'b1;
    send(vec_const(-10), {LANES{32'hFFFF_FFB0}});
    chk_eq("enable_first_bit", OW'(tree_enable), OW'(1));
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_eq("out_valid_latency", OW'(n), OW'(36));
    drain();

    // Back-to-back sweep: no enable gaps, one result per frame.
    last_pop = -1;
    gap_chk  = 1'b1;
    en_gaps  = 0;
    for (int a = -10; a <= 9; a++)
      for (int b = -10; b <= 9; b++) begin
        send(vec_ab(a, b), exp_ab(a, b));
        en_watch = 1'b1;
      end
    en_watch = 1'b0;
    drain();
    gap_chk = 1'b0;
    chk_eq("enable_gaps", OW'(en_gaps), OW'(0));

    // Extremes.
    send(vec_const(-128), {LANES{32'hFFFF_FC00}});
    send(vec_const(127),  {LANES{32'h0000_03F8}});
    send(vec_alt(),       {LANES{32'hFFFF_FFFC}});
    drain();

    // Random operands with random downstream backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom();
          send(d, calc(d));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Backpressure: two accepted, third held until the first pop.
    out_ready = 1'b0;
    send(vec_const(3), {LANES{32'd24}});
    send(vec_const(-7), {LANES{32'hFFFF_FFC8}});
    in_valid = 1'b1;
    in_data  = vec_const(11);
    cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (in_ready) cnt++;
    end
    chk_eq("bp_in_ready_blocked", OW'(cnt), OW'(0));
    chk_eq("bp_fifo_holding", OW'(out_valid), OW'(1));
    out_ready = 1'b1;
    chk_eq("bp_ready_before_pop", OW'(in_ready), OW'(0));
    @(negedge clk);
    chk_eq("bp_ready_after_pop", OW'(in_ready), OW'(1));
    if (in_ready) begin
      sb_q.push_back({LANES{32'd88}});
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();

    // Reset in the middle of a frame.
    send(vec_const(5), {LANES{32'd40}});
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    sb_q.delete();
    chk_eq("mid_rst_tree_enable", OW'(tree_enable), OW'(0));
    chk_eq("mid_rst_tree_in", OW'(tree_in), OW'(0));
    chk_eq("mid_rst_out_valid", OW'(out_valid), OW'(0));
    chk_eq("mid_rst_out_data", out_data, OW'(0));
    chk_eq("mid_rst_in_ready", OW'(in_ready), OW'(0));
    chk_eq("mid_rst_tree_reset", OW'(tree_reset), OW'(1));
    reset = 1'b0;
    @(negedge clk);
    chk_eq("mid_rst_stretch", OW'(tree_reset), OW'(1));
    @(negedge clk);
    chk_eq("mid_rst_release", OW'(tree_reset), OW'(0));
    chk_eq("mid_rst_in_ready_back", OW'(in_ready), OW'(1));
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk_eq("no_partial_result", OW'(cnt), OW'(0));
    send(vec_const(1), {LANES{32'd8}});
    drain();

    // Simultaneous accept and pop with one credit left.
    out_ready = 1'b0;
    send(vec_const(2), {LANES{32'd16}});
    for (int k = 0; k < 60 && !out_valid; k++) @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = vec_const(-1);
    chk_eq("sim_ready", OW'(in_ready), OW'(1));
    if (in_ready) sb_q.push_back({LANES{32'hFFFF_FFF8}});
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (40) @(negedge clk);
    chk_eq("sim_result_held", OW'(out_valid), OW'(1));
    chk_eq("sim_credit_one", OW'(in_ready), OW'(1));
    send(vec_const(4), {LANES{32'd32}});
    repeat (40) @(negedge clk);
    chk_eq("sim_credit_zero", OW'(in_ready), OW'(0));
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
